// File: rtl/qam_demod_sync_ctrl_pkg.sv
// Shared definitions for the QAM-16 carrier-sync controller and the demultiplier.
// Both blocks take their default timing from here, so they cannot drift apart.
package qam_demod_sync_ctrl_pkg;

   localparam int DEF_CARRIER_PERIOD = 16;
   localparam int DEF_DSP_LATENCY    = 4;
   localparam int DEF_FIFO_DEPTH     = 64;
   localparam int DEF_CNT_WIDTH      = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_ZERO = 2'd1,
      RUN       = 2'd2,
      FLUSH     = 2'd3
   } demod_state_t;

endpackage

// File: rtl/qam_demod_sync_ctrl_if.sv
// Sample-FIFO / carrier-generator / demultiplier handshake seen by the sync controller.
// master = datapath side, slave = controller side.
interface qam_demod_sync_ctrl_if;

   logic qam_valid;
   logic cor_valid;
   logic cor_zero;
   logic fifo_empty;
   logic fifo_full;
   logic fifo_rd_en;
   logic fifo_flush;
   logic lock;

   modport master (
      output qam_valid, cor_valid, cor_zero, fifo_empty, fifo_full,
      input  fifo_rd_en, fifo_flush, lock
   );

   modport slave (
      input  qam_valid, cor_valid, cor_zero, fifo_empty, fifo_full,
      output fifo_rd_en, fifo_flush, lock
   );

endinterface

// File: rtl/qam_demod_sync_ctrl_sticky_err.sv
// Sticky error flag: set has priority over clear so a fault coinciding with a clear
// is never lost.
module qam_demod_sync_ctrl_sticky_err (
   input  logic axi_clk,
   input  logic axi_rstn,
   input  logic set,
   input  logic clr,
   output logic q
);

   always_ff @(posedge axi_clk or negedge axi_rstn) begin
      if (!axi_rstn) begin
         q <= 1'b0;
      end else if (set) begin
         q <= 1'b1;
      end else if (clr) begin
         q <= 1'b0;
      end
   end

endmodule

// File: rtl/qam_demod_sync_ctrl.sv
// Carrier-synchronisation controller: starts FIFO reads on carrier zero phase, polices
// the zero-phase period, gates demultiplier validity and flushes/re-acquires on faults.
//
// state     | meaning
// ----------+----------------------------------------------------------------
// IDLE      | no valid input; waiting for samples and carrier together
// WAIT_ZERO | inputs valid; waiting for carrier zero phase to align reads
// RUN       | reading FIFO, checking zero-phase period, lock after DSP delay
// FLUSH     | FIFO/DSP flush for DSP_LATENCY+1 cycles, then back to IDLE
module qam_demod_sync_ctrl
   import qam_demod_sync_ctrl_pkg::*;
#(
   parameter int CARRIER_PERIOD = DEF_CARRIER_PERIOD,
   parameter int DSP_LATENCY    = DEF_DSP_LATENCY,
   parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
   parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
   input  logic                 axi_clk,
   input  logic                 axi_rstn,
   qam_demod_sync_ctrl_if.slave sync_if,
   input  logic                 err_clr,
   output logic [1:0]           state_o,
   output logic [CNT_WIDTH-1:0] resync_cnt,
   output logic                 err_phase,
   output logic                 err_ovf,
   output logic                 err_underrun
);

   localparam int PH_W = $clog2(CARRIER_PERIOD);
   localparam int FL_W = $clog2(DSP_LATENCY + 2);

   localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CARRIER_PERIOD - 1);
   localparam logic [PH_W-1:0] PH_FIRST  = PH_W'(1);
   localparam logic [FL_W-1:0] FLUSH_END = FL_W'(DSP_LATENCY);
   localparam logic [FL_W-1:0] LOCK_AT   = FL_W'(DSP_LATENCY + 1);

   // The FIFO must hold at least one carrier period of samples during acquisition.
   if (FIFO_DEPTH < CARRIER_PERIOD || CARRIER_PERIOD < 2) begin : g_cfg_check
      $error("qam_demod_sync_ctrl: need CARRIER_PERIOD >= 2 and FIFO_DEPTH >= CARRIER_PERIOD");
   end

   demod_state_t        state;
   logic [PH_W-1:0]     phase_cnt;
   logic [FL_W-1:0]     flush_cnt;
   logic [FL_W-1:0]     lock_cnt;
   logic                rd_en;
   logic                flush;
   logic                lock;

   logic                both_valid;
   logic                ovf_hit;
   logic                phase_bad;
   logic                run_exit;
   logic                underrun_hit;
   logic [PH_W-1:0]     phase_nxt;
   logic [FL_W-1:0]     lock_nxt;

   always_comb begin
      both_valid   = sync_if.qam_valid && sync_if.cor_valid;
      ovf_hit      = sync_if.fifo_full && sync_if.qam_valid;
      phase_bad    = (state == RUN) && both_valid &&
                     (sync_if.cor_zero != (phase_cnt == '0));
      run_exit     = (state == RUN) && (!both_valid || ovf_hit || phase_bad);
      underrun_hit = sync_if.fifo_empty && rd_en;
      phase_nxt    = (phase_cnt == PH_LAST) ? '0 : phase_cnt + 1'b1;
      lock_nxt     = (lock_cnt == LOCK_AT) ? lock_cnt : lock_cnt + 1'b1;
   end

   // Outputs default low each cycle; only a state that keeps them high re-asserts them.
   always_ff @(posedge axi_clk or negedge axi_rstn) begin
      if (!axi_rstn) begin
         state      <= IDLE;
         phase_cnt  <= '0;
         flush_cnt  <= '0;
         lock_cnt   <= '0;
         rd_en      <= 1'b0;
         flush      <= 1'b0;
         lock       <= 1'b0;
         resync_cnt <= '0;
      end else begin
         rd_en <= 1'b0;
         flush <= 1'b0;
         lock  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (both_valid) begin
                  state <= WAIT_ZERO;
               end
            end
            WAIT_ZERO: begin
               if (!both_valid) begin
                  state <= IDLE;
               end else if (sync_if.cor_zero) begin
                  state     <= RUN;
                  phase_cnt <= PH_FIRST;
                  lock_cnt  <= '0;
                  rd_en     <= 1'b1;
               end
            end
            RUN: begin
               if (run_exit) begin
                  state     <= FLUSH;
                  flush_cnt <= '0;
                  lock_cnt  <= '0;
                  flush     <= 1'b1;
                  if (resync_cnt != '1) begin
                     resync_cnt <= resync_cnt + 1'b1;
                  end
               end else begin
                  phase_cnt <= phase_nxt;
                  lock_cnt  <= lock_nxt;
                  rd_en     <= 1'b1;
                  lock      <= (lock_nxt == LOCK_AT);
               end
            end
            FLUSH: begin
               if (flush_cnt == FLUSH_END) begin
                  state <= IDLE;
               end else begin
                  flush_cnt <= flush_cnt + 1'b1;
                  flush     <= 1'b1;
               end
            end
         endcase
      end
   end

   assign sync_if.fifo_rd_en = rd_en;
   assign sync_if.fifo_flush = flush;
   assign sync_if.lock       = lock;
   assign state_o            = state;

   qam_demod_sync_ctrl_sticky_err u_err_phase (
      .axi_clk  (axi_clk),
      .axi_rstn (axi_rstn),
      .set      (phase_bad),
      .clr      (err_clr),
      .q        (err_phase)
   );

   qam_demod_sync_ctrl_sticky_err u_err_ovf (
      .axi_clk  (axi_clk),
      .axi_rstn (axi_rstn),
      .set      (ovf_hit),
      .clr      (err_clr),
      .q        (err_ovf)
   );

   qam_demod_sync_ctrl_sticky_err u_err_underrun (
      .axi_clk  (axi_clk),
      .axi_rstn (axi_rstn),
      .set      (underrun_hit),
      .clr      (err_clr),
      .q        (err_underrun)
   );

endmodule

// File: tb/tb_qam_demod_sync_ctrl.sv
// Directed bench for the carrier-sync controller: timed expectations are queued as each
// scenario is set up and compared when their cycle comes round.
module tb_qam_demod_sync_ctrl;

   localparam int P = 16;
   localparam int L = 4;

   localparam int S_RD    = 0;
   localparam int S_FLUSH = 1;
   localparam int S_LOCK  = 2;
   localparam int S_STATE = 3;
   localparam int S_RCNT  = 4;
   localparam int S_EPH   = 5;
   localparam int S_EOVF  = 6;
   localparam int S_EUND  = 7;

   typedef struct {
      int          due;
      string       tag;
      int          sig;
      logic [31:0] val;
   } exp_t;

   exp_t        sb[$];
   logic        axi_clk  = 1'b0;
   logic        axi_rstn = 1'b1;
   logic        err_clr;
   logic [1:0]  state_o;
   logic [7:0]  resync_cnt;
   logic        err_phase;
   logic        err_ovf;
   logic        err_underrun;
   int          vectors     = 0;
   int          miscompares = 0;
   int          cyc         = -1;

   qam_demod_sync_ctrl_if sync_if ();

   qam_demod_sync_ctrl #(
      .CARRIER_PERIOD (P),
      .DSP_LATENCY    (L),
      .FIFO_DEPTH     (64),
      .CNT_WIDTH      (8)
   ) dut (
      .axi_clk      (axi_clk),
      .axi_rstn     (axi_rstn),
      .sync_if      (sync_if.slave),
      .err_clr      (err_clr),
      .state_o      (state_o),
      .resync_cnt   (resync_cnt),
      .err_phase    (err_phase),
      .err_ovf      (err_ovf),
      .err_underrun (err_underrun)
   );

   always #5 axi_clk = ~axi_clk;

   function automatic logic [31:0] obs(int s);
      case (s)
         S_RD:    obs = {31'b0, sync_if.fifo_rd_en};
         S_FLUSH: obs = {31'b0, sync_if.fifo_flush};
         S_LOCK:  obs = {31'b0, sync_if.lock};
         S_STATE: obs = {30'b0, state_o};
         S_RCNT:  obs = {24'b0, resync_cnt};
         S_EPH:   obs = {31'b0, err_phase};
         S_EOVF:  obs = {31'b0, err_ovf};
         S_EUND:  obs = {31'b0, err_underrun};
         default: obs = 'x;
      endcase
   endfunction

   function automatic void expect_at(int due, string tag, int s, logic [31:0] v);
      sb.push_back('{due, tag, s, v});
   endfunction

   function automatic void expect_reset_vals(int due, string tag);
      expect_at(due, tag, S_RD,    0);
      expect_at(due, tag, S_FLUSH, 0);
      expect_at(due, tag, S_LOCK,  0);
      expect_at(due, tag, S_STATE, 0);
      expect_at(due, tag, S_RCNT,  0);
      expect_at(due, tag, S_EPH,   0);
      expect_at(due, tag, S_EOVF,  0);
      expect_at(due, tag, S_EUND,  0);
   endfunction

   // Carrier zero-phase schedule: nominal from 10, one early arrival at 1017 (phase
   // shifted from then on), a second slip at 1090, then a stuck-high stretch that forces
   // a resync every 8 cycles, then a fresh schedule from 3610.
   function automatic logic zero_at(int c);
      if (c < 1017)      return (c >= 10) && ((c - 10) % P == 0);
      else if (c < 1090) return ((c - 1017) % P == 0);
      else if (c < 1100) return (c == 1090);
      else if (c < 3600) return 1'b1;
      else               return (c >= 3610) && ((c - 3610) % P == 0);
   endfunction

   task automatic drive(int c);
      sync_if.qam_valid  = 1'b1;
      sync_if.cor_valid  = (c != 1060);
      sync_if.fifo_full  = (c == 1060);
      sync_if.fifo_empty = (c >= 1045 && c <= 1047);
      sync_if.cor_zero   = zero_at(c);
      err_clr            = (c == 1055 || c == 1090);
   endtask

   task automatic check_due();
      exp_t keep[$];
      foreach (sb[i]) begin
         if (sb[i].due == cyc) begin
            logic [31:0] o;
            o = obs(sb[i].sig);
            vectors++;
            assert (o === sb[i].val) else begin
               miscompares++;
               $error("FAIL %s cyc=%0d observed=%0h expected=%0h", sb[i].tag, cyc, o, sb[i].val);
            end
         end else begin
            keep.push_back(sb[i]);
         end
      end
      sb = keep;
   endtask

   task automatic tick();
      @(negedge axi_clk);
      check_due();
      @(posedge axi_clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(int n);
      while (cyc < n) begin
         drive(cyc);
         tick();
      end
   endtask

   initial begin
      sync_if.qam_valid  = 1'b0;
      sync_if.cor_valid  = 1'b0;
      sync_if.cor_zero   = 1'b0;
      sync_if.fifo_empty = 1'b0;
      sync_if.fifo_full  = 1'b0;
      err_clr            = 1'b0;

      // reset values, asynchronously applied before any clock edge
      #1 axi_rstn = 1'b0;
      #1;
      expect_reset_vals(-1, "por");
      check_due();
      repeat (2) @(posedge axi_clk);
      #1;
      axi_rstn = 1'b1;
      cyc      = 0;

      // acquisition: zero at 10 -> reads at 11, lock at 16
      expect_at(0,  "acq_idle",  S_STATE, 0);
      expect_at(1,  "acq_wz",    S_STATE, 1);
      expect_at(10, "acq_rd0",   S_RD,    0);
      expect_at(11, "acq_rd1",   S_RD,    1);
      expect_at(11, "acq_run",   S_STATE, 2);
      expect_at(15, "acq_lock0", S_LOCK,  0);
      expect_at(16, "acq_lock1", S_LOCK,  1);
      run_to(1000);
      expect_at(1000, "acq_eph",   S_EPH,   0);
      expect_at(1000, "acq_eovf",  S_EOVF,  0);
      expect_at(1000, "acq_eund",  S_EUND,  0);
      expect_at(1000, "acq_lock",  S_LOCK,  1);
      expect_at(1000, "acq_state", S_STATE, 2);
      expect_at(1000, "acq_rcnt",  S_RCNT,  0);
      run_to(1016);

      // phase slip: zero one cycle early at 1017
      expect_at(1017, "slip_pre_lock", S_LOCK,  1);
      expect_at(1017, "slip_pre_eph",  S_EPH,   0);
      expect_at(1018, "slip_eph",      S_EPH,   1);
      expect_at(1018, "slip_lock",     S_LOCK,  0);
      expect_at(1018, "slip_rd",       S_RD,    0);
      expect_at(1018, "slip_state",    S_STATE, 3);
      expect_at(1018, "slip_rcnt",     S_RCNT,  1);
      for (int c = 1018; c <= 1022; c++) expect_at(c, "slip_flush", S_FLUSH, 1);
      expect_at(1023, "slip_flush_end", S_FLUSH, 0);
      expect_at(1023, "slip_idle",      S_STATE, 0);
      expect_at(1024, "slip_wz",        S_STATE, 1);
      expect_at(1034, "reacq_rd",       S_RD,    1);
      expect_at(1034, "reacq_run",      S_STATE, 2);
      expect_at(1038, "reacq_lock0",    S_LOCK,  0);
      expect_at(1039, "reacq_lock1",    S_LOCK,  1);
      run_to(1044);

      // underrun for three cycles in RUN
      expect_at(1045, "und_pre", S_EUND, 0);
      expect_at(1046, "und_set", S_EUND, 1);
      for (int c = 1046; c <= 1048; c++) begin
         expect_at(c, "und_state", S_STATE, 2);
         expect_at(c, "und_lock",  S_LOCK,  1);
      end
      expect_at(1050, "und_sticky", S_EUND, 1);
      run_to(1055);

      // plain error clear
      expect_at(1056, "clr_eph",  S_EPH,  0);
      expect_at(1056, "clr_eund", S_EUND, 0);
      run_to(1060);

      // overflow and loss of cor_valid together
      expect_at(1060, "ovf_pre",   S_EOVF,  0);
      expect_at(1061, "ovf_state", S_STATE, 3);
      expect_at(1061, "ovf_err",   S_EOVF,  1);
      expect_at(1061, "ovf_rcnt",  S_RCNT,  2);
      expect_at(1061, "ovf_lock",  S_LOCK,  0);
      expect_at(1061, "ovf_flush", S_FLUSH, 1);
      expect_at(1061, "ovf_eph",   S_EPH,   0);
      expect_at(1062, "ovf_rcnt2", S_RCNT,  2);
      expect_at(1062, "ovf_err2",  S_EOVF,  1);
      expect_at(1066, "ovf_idle",  S_STATE, 0);
      expect_at(1067, "ovf_wz",    S_STATE, 1);
      expect_at(1082, "ovf_rerun", S_STATE, 2);
      run_to(1090);

      // err_clr coincident with a new phase error
      expect_at(1091, "clrset_eph",   S_EPH,   1);
      expect_at(1091, "clrset_eovf",  S_EOVF,  0);
      expect_at(1091, "clrset_rcnt",  S_RCNT,  3);
      expect_at(1091, "clrset_state", S_STATE, 3);
      run_to(1100);

      // repeated slips: resync_cnt saturates at 255
      expect_at(1102, "sat_first",  S_RCNT,  4);
      expect_at(1102, "sat_flush",  S_STATE, 3);
      expect_at(3102, "sat_254",    S_RCNT,  254);
      expect_at(3110, "sat_255",    S_RCNT,  255);
      expect_at(3605, "sat_hold",   S_RCNT,  255);
      expect_at(3611, "rst_pre_rd", S_RD,    1);
      expect_at(3615, "rst_pre_l0", S_LOCK,  0);
      expect_at(3616, "rst_pre_l1", S_LOCK,  1);
      run_to(3620);

      // asynchronous reset in the middle of a RUN cycle
      drive(cyc);
      #2 axi_rstn = 1'b0;
      #1;
      expect_reset_vals(cyc, "rst_async");
      check_due();
      tick();
      expect_at(3621, "rst_flush_a", S_FLUSH, 0);
      expect_at(3622, "rst_flush_b", S_FLUSH, 0);
      expect_at(3622, "rst_state",   S_STATE, 0);
      run_to(3623);
      axi_rstn = 1'b1;
      expect_at(3623, "rel_flush", S_FLUSH, 0);
      expect_at(3623, "rel_idle",  S_STATE, 0);
      expect_at(3624, "rel_wz",    S_STATE, 1);
      run_to(3626);

      foreach (sb[i]) begin
         vectors++;
         assert (sb[i].due >= cyc) else begin
            miscompares++;
            $error("FAIL %s unchecked due=%0d expected=%0h", sb[i].tag, sb[i].due, sb[i].val);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/qam_demod_sync_ctrl.md
# qam_demod_sync_ctrl

Carrier-synchronisation controller for the QAM-16 receive path. Sits between the sample FIFO, the CORDIC carrier generator and the I/Q demultiplier. It decides when FIFO reads start, checks that the carrier zero-phase flag keeps recurring on the expected period, and gates demultiplier output validity. On loss of input, phase error or FIFO overflow it flushes and re-acquires.

## Interface
Parameters:
- CARRIER_PERIOD, 16, carrier period in axi_clk cycles (≥2); cor_zero is expected every CARRIER_PERIOD cycles.
- DSP_LATENCY, 4, demultiplier DSP pipeline depth in cycles.
- FIFO_DEPTH, 64, sample FIFO write depth; must be ≥ CARRIER_PERIOD.
- CNT_WIDTH, 8, width of the resync counter.

Ports:
- axi_clk  in  1  clock.
- axi_rstn  in  1  reset, asynchronous, active-low.
- qam_valid  in  1  incoming sample valid (FIFO write enable).
- cor_valid  in  1  carrier generator output valid.
- cor_zero  in  1  carrier at zero phase this cycle.
- fifo_empty  in  1  sample FIFO empty.
- fifo_full  in  1  sample FIFO full.
- fifo_rd_en  out  1  FIFO read enable.
- fifo_flush  out  1  FIFO synchronous reset request.
- lock  out  1  demultiplier output is aligned and valid.
- state_o  out  2  current FSM state, for debug.
- resync_cnt  out  CNT_WIDTH  saturating count of RUN→FLUSH exits.
- err_phase  out  1  sticky: cor_zero period mismatch.
- err_ovf  out  1  sticky: FIFO full while qam_valid high.
- err_underrun  out  1  sticky: fifo_empty while fifo_rd_en high.
- err_clr  in  1  single-cycle pulse; clears all three sticky errors.

## Operation
- States: IDLE(0), WAIT_ZERO(1), RUN(2), FLUSH(3).
- IDLE: rd_en=0. Go to WAIT_ZERO when qam_valid && cor_valid.
- WAIT_ZERO: if !qam_valid || !cor_valid, go to IDLE. Otherwise, if cor_zero, go to RUN and load phase_cnt=1.
- RUN: fifo_rd_en=1. phase_cnt increments modulo CARRIER_PERIOD. The zero check is cor_zero == (phase_cnt==0). On mismatch, set err_phase and go to FLUSH.
- RUN exit priority, highest first: loss of qam_valid/cor_valid, overflow (fifo_full && qam_valid, sets err_ovf), phase mismatch. Every exit to FLUSH increments resync_cnt, saturating at all-ones.
- Underrun (fifo_empty && fifo_rd_en) sets err_underrun only. It causes no state change.
- FLUSH: fifo_rd_en=0, fifo_flush=1 for all FLUSH cycles. FLUSH lasts exactly DSP_LATENCY+1 cycles, using flush_cnt, then goes to IDLE.
- lock: rises DSP_LATENCY+1 cycles after RUN entry, matching the demultiplier valid delay. It falls in the same cycle the FSM leaves RUN.
- Sticky error bits: a set in the same cycle as err_clr wins.

## Timing
- All outputs are registered.
- Reset values: state IDLE, fifo_rd_en 0, fifo_flush 0, lock 0, resync_cnt 0, all err_* 0, counters 0.
- Reset asserted mid-RUN forces IDLE asynchronously. No flush pulse is produced.
- cor_zero sampled in WAIT_ZERO at cycle t gives fifo_rd_en=1 at t+1.
- lock=1 from t+1+DSP_LATENCY+1 onward, provided the FSM is still in RUN.
- Exit decision at cycle t gives fifo_rd_en=0 and fifo_flush=1 at t+1. fifo_flush stays high for DSP_LATENCY+1 cycles, then the FSM is in IDLE.
- Re-entry to WAIT_ZERO can occur in the first cycle after IDLE is reached.
- phase_cnt width is $clog2(CARRIER_PERIOD).
- flush_cnt width is $clog2(DSP_LATENCY+2).
- lock_cnt saturates at DSP_LATENCY+1.

## Structure
- Shared package parameter_def holds:
  - typedef enum logic [1:0] demod_state_t {IDLE, WAIT_ZERO, RUN, FLUSH};
  - CARRIER_PERIOD and DSP_LATENCY defaults, so the demultiplier and this controller agree.
- One sub-module is natural: sticky_err. It is a set/clear register with set priority and is instantiated three times.
- All remaining logic is the FSM plus three counters in one module.

## Test plan
All scenarios use CARRIER_PERIOD=16 and DSP_LATENCY=4.
- Acquisition: qam_valid and cor_valid high, cor_zero at cycle 10 and every 16 cycles after. Required: fifo_rd_en=1 at 11, lock=1 at 16, no errors over 1000 cycles.
- Phase slip: cor_zero arrives 1 cycle early once. Required: err_phase=1, lock=0 the same cycle, fifo_flush high for 5 cycles, resync_cnt=1, then re-acquisition on the next cor_zero.
- Overflow vs loss of valid in the same cycle: drop cor_valid and hold fifo_full with qam_valid high. Required: exit to FLUSH with err_ovf still set; resync_cnt increments by 1, not 2.
- Underrun: force fifo_empty for 3 cycles in RUN. Required: err_underrun=1, state stays RUN, lock stays 1.
- Reset mid-RUN: deassert axi_rstn asynchronously mid-cycle. Required: all outputs at reset values before the next clock edge, and no fifo_flush pulse.
- err_clr coincident with a new phase error: err_phase stays 1. Also force 300 slips: resync_cnt saturates at 255.
